// File: rtl/byte_receiver.sv
// byte_receiver: serial-to-parallel word receiver, MSB first.
// A shift register collects bits; each completed word is handed to a
// separate holding register (out/valid) so reception never stalls while
// the consumer has not yet acknowledged. A word that completes while the
// holding register is still occupied and not being acknowledged is dropped
// and recorded in the sticky overrun flag.
module byte_receiver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             sync,
    input  logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic [5:0]       bit_count,
    output logic             overrun
);

    localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    // Word as it would look with the current input bit shifted in at bit 0.
    logic [WIDTH-1:0] shifted;
    logic             complete;

    assign shifted = {shift_q[WIDTH-2:0], in};

    // Collection side: sync wins over enable; the WIDTH-th bit completes the word.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (sync) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (enable) begin
            if (cnt_q == LAST_BIT) begin
                // Completed word leaves through 'shifted'; start the next one clean.
                shift_d  = '0;
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                shift_d = shifted;
                cnt_d   = cnt_q + 6'd1;
            end
        end
    end

    // Holding side: hand-off of completed words, ack handling and overrun.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (complete) begin
            if (!valid_q) begin
                out_d   = shifted;
                valid_d = 1'b1;
            end else if (ack) begin
                // Old word consumed on this very edge, so the new one fits.
                out_d     = shifted;
                valid_d   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                // Holding register busy: keep the old word, drop the new one.
                overrun_d = 1'b1;
            end
        end else if (ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State registers with immediate (asynchronous) clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign bit_count = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_byte_receiver.sv
// Testbench for byte_receiver (WIDTH=32): queue-based scoreboard of the
// words expected to land in the holding register, plus a small model of
// valid/overrun/bit_count.
module tb_byte_receiver;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             in = 1'b0;
    logic             sync = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic [5:0]       bit_count;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_out = '0;
    logic             m_valid = 1'b0;
    logic             m_ovr = 1'b0;
    int               m_cnt = 0;

    byte_receiver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (in),
        .sync      (sync),
        .ack       (ack),
        .out       (out),
        .valid     (valid),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Verify holding register against the scoreboard / model.
    task automatic check_hold(input string tag);
        if (exp_q.size() > 0) m_out = exp_q.pop_front();
        check_val({tag, "_out"}, 64'(out), 64'(m_out));
        check_val({tag, "_valid"}, 64'(valid), 64'(m_valid));
        check_val({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
        check_val({tag, "_cnt"}, 64'(bit_count), 64'(m_cnt));
    endtask

    // Send nbits of word MSB first; gap inserts an enable=0 cycle after each bit.
    // ack_last raises ack on the edge that samples the final bit.
    task automatic send_bits(input logic [WIDTH-1:0] word, input int nbits,
                             input bit gap, input bit ack_last, input string tag);
        for (int i = nbits - 1; i >= 0; i--) begin
            enable = 1'b1;
            in     = word[i];
            ack    = (i == 0) ? ack_last : 1'b0;
            if (m_cnt == WIDTH - 1) begin
                if (!m_valid || ack) begin
                    exp_q.push_back(word);
                    m_valid = 1'b1;
                    if (m_valid && ack) m_ovr = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            tick();
            ack = 1'b0;
            if (gap) begin
                enable = 1'b0;
                in     = $urandom_range(0, 1);
                tick();
                check_val({tag, "_hold_cnt"}, 64'(bit_count), 64'(m_cnt));
            end
        end
        enable = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        tick();
        ack = 1'b0;
        check_hold(tag);
        $display("ack %s: out=%h valid=%0d overrun=%0d", tag, out, valid, overrun);
    endtask

    initial begin
        // Reset state, no clock edge needed.
        #2;
        check_hold("reset");
        #10 reset = 1'b0;
        tick();
        check_hold("post_reset");

        // Plain word.
        send_bits(32'hDEADBEEF, 32, 1'b0, 1'b0, "w1");
        check_hold("deadbeef");
        $display("word deadbeef: out=%h valid=%0d", out, valid);
        do_ack("ack1");
        do_ack("ack_idle");  // ack with valid=0 is ignored

        // Enable toggling every cycle.
        send_bits(32'h12345678, 32, 1'b1, 1'b0, "tog");
        check_hold("toggle");
        $display("word 12345678 (gapped): out=%h valid=%0d", out, valid);
        do_ack("ack2");

        // Overrun: second word dropped.
        send_bits(32'hA5A5A5A5, 32, 1'b0, 1'b0, "a5");
        check_hold("a5");
        send_bits(32'hFFFFFFFF, 32, 1'b0, 1'b0, "ff");
        check_hold("overrun");
        $display("word ffffffff dropped: out=%h overrun=%0d", out, overrun);
        do_ack("ack_ovr");

        // Ack on the exact completion edge.
        send_bits(32'h11111111, 32, 1'b0, 1'b0, "wa");
        check_hold("word_a");
        send_bits(32'h0F0F0F0F, 32, 1'b0, 1'b1, "wb");
        check_hold("ack_same_edge");
        $display("word 0f0f0f0f with ack: out=%h valid=%0d overrun=%0d", out, valid, overrun);

        // Sync mid-word (valid still 1: sync must not touch it).
        send_bits(32'h000003FF, 10, 1'b0, 1'b0, "part");
        check_val("part_cnt", 64'(bit_count), 64'd10);
        sync = 1'b1; enable = 1'b1; in = 1'b1;
        m_cnt = 0;
        tick();
        sync = 1'b0; enable = 1'b0;
        check_hold("sync");
        do_ack("ack3");
        send_bits(32'hCAFEF00D, 32, 1'b0, 1'b0, "cafe");
        check_hold("cafe");
        $display("word cafef00d after sync: out=%h valid=%0d", out, valid);

        // Asynchronous reset mid-word with valid=1.
        send_bits(32'h0001FFFF, 17, 1'b0, 1'b0, "mid");
        check_val("mid_cnt", 64'(bit_count), 64'd17);
        check_val("mid_valid", 64'(valid), 64'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_cnt = 0;
        #1;
        check_hold("async_reset");
        #1 reset = 1'b0;
        send_bits(32'h13579BDF, 32, 1'b0, 1'b0, "clean");
        check_hold("clean");
        $display("word 13579bdf after reset: out=%h valid=%0d", out, valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_receiver.md
BYTE_RECEIVER -- requirements
Module: byte_receiver

Interface
REQ-001 Parameter: WIDTH, default 32, number of bits per received word (legal range 2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  when high at a clk edge, the bit on `in` is sampled.
REQ-005 Port: in  input  1  serial data bit, MSB of word first.
REQ-006 Port: sync  input  1  discards any partially received word.
REQ-007 Port: ack  input  1  consumer acknowledges the word held on `out`.
REQ-008 Port: out  output  WIDTH  last completed word (holding register).
REQ-009 Port: valid  output  1  `out` holds an unacknowledged word.
REQ-010 Port: bit_count  output  6  bits collected into the current partial word (0..WIDTH-1).
REQ-011 Port: overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 Shift register SHALL load each sampled bit at bit position 0, shifting left, so the first received bit ends in out[WIDTH-1].
REQ-013 bit_count SHALL increment by 1 on each edge where enable=1 and sync=0.
REQ-014 On the edge sampling the WIDTH-th bit, bit_count SHALL wrap to 0 and the word SHALL complete.
REQ-015 Completion latency: the completed word SHALL appear on `out` with valid=1 in the cycle immediately after the edge that sampled its last bit.
REQ-016 The shift register SHALL be double-buffered against `out`: reception of the next word SHALL continue while valid=1.
REQ-017 Completion with valid=0 SHALL load `out` and set valid=1.
REQ-018 ack=1 with valid=1 and no completion SHALL clear valid; `out` SHALL keep its value.
REQ-019 ack=1 while valid=0 SHALL be ignored.
REQ-020 Completion with valid=1 and ack=1 on the same edge SHALL load the new word into `out` and keep valid=1, without setting overrun.
REQ-021 Completion with valid=1 and ack=0 SHALL keep the old `out` unchanged, drop the new word, set overrun=1, and keep valid=1.
REQ-022 overrun SHALL remain set until reset, or until an edge with ack=1 and valid=1 where no new overrun occurs.
REQ-023 sync=1 SHALL clear bit_count to 0 and discard the partial word, taking priority over enable on the same edge.
REQ-024 sync SHALL NOT affect `out`, valid or overrun.
REQ-025 enable=0 SHALL hold bit_count and the shift register.
REQ-026 Value of `in` SHALL be ignored when enable=0.
REQ-027 Decode order per edge: sync, then the sampled bit, then completion, then ack.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, force out=0, valid=0, bit_count=0, overrun=0, and clear the shift register.
REQ-029 reset asserted mid-word SHALL discard the partial word.
REQ-030 After reset release, the first enabled edge SHALL be treated as bit WIDTH-1 of a new word.
REQ-031 reset SHALL override every other input.

Verification
REQ-032 WIDTH=32; feed 0xDEADBEEF MSB first, enable=1 for 32 cycles -> cycle after 32nd edge: out=0xDEADBEEF, valid=1, bit_count=0, overrun=0.
REQ-033 Feed 0x12345678 with enable toggling 1/0 every cycle -> out=0x12345678 after 64 cycles; bit_count holds during enable=0 cycles.
REQ-034 Complete 0xA5A5A5A5, no ack; feed 0xFFFFFFFF -> out stays 0xA5A5A5A5, valid=1, overrun=1; ack=1 next cycle -> valid=0, overrun=0.
REQ-035 Complete word A; ack=1 on the exact edge word B=0x0F0F0F0F completes -> out=0x0F0F0F0F, valid=1, overrun=0.
REQ-036 Send 10 bits, then sync=1 with enable=1 for one cycle, then send 0xCAFEF00D -> bit_count=0 after sync; out=0xCAFEF00D.
REQ-037 Assert reset asynchronously mid-word (bit_count=17, valid=1) -> all outputs 0 before the next clk edge; the next 32 enabled bits form a clean word.
